led_sequencer: RTL and testbench
================================

# led_sequencer

Parametrised multi-channel running-LED sequencer driving a board's discrete/RGB LEDs from the system clock. It divides `clk` into a step tick, advances a one-hot pattern in one of four modes (rotate right, rotate left, bounce, hold), and applies global PWM brightness to the lit channel. It generalises the fixed 3-channel, fixed-rate, rotate-only RGB runner to N channels with selectable direction, bounce, brightness, enable and output polarity.

## Interface

- `N_LED`, 3: number of LED channels; must be ≥ 2.
- `TICK_DIV`, 24000000: `clk` cycles per pattern step; must be ≥ 1. Counter width is `$clog2(TICK_DIV)`, minimum 1.
- `PWM_BITS`, 8: brightness resolution.
- `ACTIVE_LOW`, 0: 1 inverts every `led` bit at the output.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `en`  in  1  1 = prescaler runs and the pattern steps; 0 = prescaler and pattern freeze.
- `mode`  in  2  00 rotate right, 01 rotate left, 10 bounce, 11 hold.
- `duty`  in  PWM_BITS  brightness; 0 = off, all-ones = fully on.
- `led`  out  N_LED  registered LED drive.
- `step`  out  1  one-cycle pulse marking each pattern update.

## Operation

- **Prescaler `cnt`.** When `en`=1, `cnt` increments each cycle. At `TICK_DIV-1` it wraps to 0 and a step occurs on that same edge. When `en`=0, `cnt` holds. With `TICK_DIV`=1, a step occurs every cycle while `en`=1.
- **Pattern register `pat`.** Reset value is one-hot bit 0. On a step edge, `mode` is sampled and `pat` is updated as follows:
  - rotate right: `pat <= {pat[0], pat[N_LED-1:1]}`.
  - rotate left: `pat <= {pat[N_LED-2:0], pat[N_LED-1]}`.
  - bounce uses a direction register `dir` (0 = up, reset value 0):
    - `dir`=0: if `pat[N_LED-1]`, then `dir<=1` and shift right; else shift left.
    - `dir`=1: if `pat[0]`, then `dir<=0` and shift left; else shift right.
  - hold: `pat` is unchanged, but `step` still pulses.
  - `dir` is modified only in bounce mode; it keeps its value across mode changes.
- **Mode changes.** A change to `mode` between steps takes effect at the next step only.
- **PWM.**
  - `pwm_cnt` (PWM_BITS wide) is free-running regardless of `en` and wraps from all-ones to 0.
  - `duty_q` loads `duty` on the edge where `pwm_cnt` wraps to 0, so brightness changes are glitch-free and take effect at the next PWM period.
  - `on = (duty_q == all-ones) | (pwm_cnt < duty_q)`.
- **Output.** `led <= (pat & {N_LED{on}}) ^ {N_LED{ACTIVE_LOW}}`.
- **Reset values.** `cnt`=0, `pwm_cnt`=0, `duty_q`=0, `pat`=one-hot bit 0, `dir`=0, `step`=0, `led` = all off (all 0, or all 1 if `ACTIVE_LOW`).
- **Reset mid-operation.** All state returns to the reset values immediately (asynchronously). After release, the first step occurs `TICK_DIV` enabled cycles later.

## Timing

- **`step`.** Registered; it is high during the cycle after the step edge, which is the first cycle in which the new `pat` is held.
- **`led` latency.** One cycle after `pat`, `pwm_cnt` and `duty_q`; the new pattern therefore appears on `led` one cycle after `step` rises.
- **Step spacing.** Steps are exactly `TICK_DIV` enabled cycles apart; cycles with `en`=0 do not count.
- **`duty` latency.** A `duty` change is visible on `led` within 2^PWM_BITS + 1 cycles.
- **Falling `en`.** If `en` falls in the same cycle in which `cnt` = `TICK_DIV-1`, no step occurs; `cnt` holds at `TICK_DIV-1`, and the step fires on the first enabled edge afterwards.

## Test plan

Unless noted, parameters are `N_LED`=4, `TICK_DIV`=4, `PWM_BITS`=3, `ACTIVE_LOW`=0.

- **Rotate right.** Reset, then `en`=1, `mode`=00, `duty`=7 → `step` every 4 cycles; `led` sequence 0001, 1000, 0100, 0010, 0001; `led` = 0000 while reset is asserted.
- **Rotate left, bounce, mode switch.**
  - `mode`=01 → 0001, 0010, 0100, 1000, 0001.
  - `mode`=10 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - Switch `mode` mid-step → the old rule applies until the next step.
- **Brightness.**
  - `duty`=3 → the lit LED is high 3 of every 8 cycles.
  - `duty`=0 → `led`=0000 constantly.
  - `duty`=7 → the lit LED is high constantly.
  - `duty` changed mid-period → the new duty applies only after `pwm_cnt` wraps.
- **Enable and hold.**
  - Drop `en` for 10 cycles at `cnt`=2 → no `step` and `pat` frozen; the next step comes 2 enabled cycles after `en` returns.
  - `mode`=11 → `step` keeps pulsing while `pat` is unchanged.
- **Asynchronous reset mid-run.** Assert `reset` between clock edges while `pat`=0100 → `led`=0000 and `step`=0 immediately; after release, `pat`=0001 and the first step arrives 4 cycles later.
- **Parameter corners.**
  - `ACTIVE_LOW`=1 → `led`=1111 at reset, and the lit channel reads 0.
  - `TICK_DIV`=1, `N_LED`=2, rotate right → `led` alternates 10, 01 every cycle, with `step` held high.

Source files
------------

// File: rtl/led_sequencer.sv
// led_sequencer
// Running-LED sequencer for N_LED discrete/RGB channels. A prescaler divides
// clk into a step tick. Each step moves a one-hot pattern according to mode:
// rotate right, rotate left, bounce or hold. A free-running PWM counter then
// gates the lit channel to set its brightness.
//
// Ports
//   clk    in  1         system clock
//   reset  in  1         asynchronous reset, active high
//   en     in  1         1 = prescaler and pattern run, 0 = both freeze
//   mode   in  2         00 rotate right, 01 rotate left, 10 bounce, 11 hold
//   duty   in  PWM_BITS  brightness: 0 = off, all-ones = fully on
//   led    out N_LED     registered LED drive, inverted when ACTIVE_LOW = 1
//   step   out 1         one-cycle pulse in the first cycle a new pattern is held
module led_sequencer #(
  parameter int N_LED      = 3,
  parameter int TICK_DIV   = 24000000,
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LED-1:0]    led,
  output logic                step
);

  localparam int                  CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [N_LED-1:0]    PAT_RST = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0]    LED_OFF = {N_LED{ACTIVE_LOW}};
  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {
    MODE_RIGHT  = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Move the lit bit one position toward bit 0, wrapping bit 0 to the top.
  function automatic logic [N_LED-1:0] rot_right(input logic [N_LED-1:0] p);
    return {p[0], p[N_LED-1:1]};
  endfunction

  // Move the lit bit one position toward the top, wrapping the top bit to bit 0.
  function automatic logic [N_LED-1:0] rot_left(input logic [N_LED-1:0] p);
    return {p[N_LED-2:0], p[N_LED-1]};
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_LED-1:0]    pat_q, pat_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic                tick_s;
  logic                on_s;

  // A step fires only on an enabled edge at terminal count. If en drops
  // at terminal count, cnt stays parked there and the step fires on the
  // next enabled edge.
  assign tick_s = en & (cnt_q == CNT_MAX);

  // Drive the PWM gate. All-ones duty is forced fully on because
  // pwm_cnt < all-ones misses exactly one cycle per period.
  assign on_s = (duty_q == PWM_MAX) | (pwm_cnt_q < duty_q);

  // Compute the next prescaler value.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (tick_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Compute the next pattern, bounce direction and step pulse.
  // mode is sampled only here, so a mode change takes effect at the next step.
  always_comb begin
    pat_d  = pat_q;
    dir_d  = dir_q;
    step_d = tick_s;
    if (tick_s) begin
      case (mode_e'(mode))
        MODE_RIGHT:  pat_d = rot_right(pat_q);
        MODE_LEFT:   pat_d = rot_left(pat_q);
        MODE_BOUNCE: begin
          // dir is written only here and persists across other modes.
          if (!dir_q) begin
            if (pat_q[N_LED-1]) begin
              dir_d = 1'b1;
              pat_d = rot_right(pat_q);
            end else begin
              pat_d = rot_left(pat_q);
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = 1'b0;
              pat_d = rot_left(pat_q);
            end else begin
              pat_d = rot_right(pat_q);
            end
          end
        end
        MODE_HOLD:   pat_d = pat_q;
        default:     pat_d = pat_q;
      endcase
    end else begin
      pat_d = pat_q;
    end
  end

  // Compute the PWM counter and duty capture. pwm_cnt free-runs
  // independently of en. duty is captured only on the wrap edge, so a
  // brightness change never cuts a PWM period short.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    if (pwm_cnt_q == PWM_MAX) begin
      duty_d = duty;
    end else begin
      duty_d = duty_q;
    end
  end

  // Gate the pattern with PWM and apply output polarity.
  always_comb begin
    led_d = (pat_q & {N_LED{on_s}}) ^ LED_OFF;
  end

  // Hold all state registers; reset clears them asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= {CNT_W{1'b0}};
      pat_q     <= PAT_RST;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      pwm_cnt_q <= {PWM_BITS{1'b0}};
      duty_q    <= {PWM_BITS{1'b0}};
      led_q     <= LED_OFF;
    end else begin
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      led_q     <= led_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer. The main instance uses N_LED=4, TICK_DIV=4,
// PWM_BITS=3. Two corner instances share the same stimulus: one with
// ACTIVE_LOW=1, and one with TICK_DIV=1 and N_LED=2.
// The stimulus pushes the pattern it expects after each step into a
// queue. A monitor waits for each step pulse, then compares led on the
// following cycle against the head of the queue.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [2:0] duty;
  logic [3:0] led;
  logic       step;
  logic [3:0] led_al;
  logic       step_al;
  logic [1:0] led_t1;
  logic       step_t1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] exp_q[$];
  logic [3:0] cur_pat;
  logic       step_seen = 1'b0;
  logic [2:0] pwm_m;

  led_sequencer #(.N_LED(4), .TICK_DIV(4), .PWM_BITS(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .duty(duty),
    .led(led), .step(step)
  );

  led_sequencer #(.N_LED(4), .TICK_DIV(4), .PWM_BITS(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .duty(duty),
    .led(led_al), .step(step_al)
  );

  led_sequencer #(.N_LED(2), .TICK_DIV(1), .PWM_BITS(3), .ACTIVE_LOW(1'b0)) dut_t1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .duty(duty),
    .led(led_t1), .step(step_t1)
  );

  always #5 clk = ~clk;

  // Independent model of the PWM counter phase (value held after each edge).
  always @(posedge clk or posedge reset) begin
    if (reset) pwm_m <= 3'd0;
    else       pwm_m <= pwm_m + 3'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input logic [3:0] p);
    exp_q.push_back(p);
    cur_pat = p;
  endtask

  // Scoreboard monitor: after each step pulse, the next led value must equal the queued pattern.
  always @(negedge clk) begin
    if (reset) begin
      step_seen = 1'b0;
    end else begin
      if (step_seen) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_step", 32'd1, 32'd0);
        end else begin
          check("sb_led", {28'd0, led}, {28'd0, exp_q.pop_front()});
        end
      end
      step_seen = step;
    end
  end

  // Measure brightness over 8 consecutive cycles of the currently lit channel.
  task automatic measure(input string name, input int exp_hi);
    int hi = 0;
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (led == cur_pat) hi++;
      else if (led != 4'b0000) bad++;
    end
    check({name, "_high"}, hi, exp_hi);
    check({name, "_other"}, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

  initial begin
    int hi_cnt;
    reset = 1'b1; en = 1'b0; mode = 2'b00; duty = 3'd7;
    cur_pat = 4'b0001;
    tick(3);
    check("rst_led", {28'd0, led}, 32'h0);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_led_al", {28'd0, led_al}, 32'hF);
    check("rst_led_t1", {30'd0, led_t1}, 32'd0);
    reset = 1'b0;
    tick(10);  // duty 7 captured at the first PWM wrap
    check("idle_led", {28'd0, led}, 32'h1);
    check("idle_led_al", {28'd0, led_al}, 32'hE);
    check("idle_led_t1", {30'd0, led_t1}, 32'h1);
    check("idle_step", {31'd0, step}, 32'd0);

    // Rotate right; the TICK_DIV=1 instance toggles every cycle.
    en = 1'b1;
    expect_step(4'b1000); expect_step(4'b0100); expect_step(4'b0010); expect_step(4'b0001);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k <= 4) begin
        check("t1_step", {31'd0, step_t1}, 32'd1);
        check("t1_led", {30'd0, led_t1}, (k % 2 == 1) ? 32'h1 : 32'h2);
      end
    end

    // Rotate left.
    mode = 2'b01;
    expect_step(4'b0010); expect_step(4'b0100); expect_step(4'b1000); expect_step(4'b0001);
    tick(16);

    // Bounce.
    mode = 2'b10;
    expect_step(4'b0010); expect_step(4'b0100); expect_step(4'b1000); expect_step(4'b0100);
    expect_step(4'b0010); expect_step(4'b0001); expect_step(4'b0010);
    tick(28);

    // Mode change late in the interval: the value at the step edge wins.
    mode = 2'b01;
    tick(3);
    mode = 2'b00;
    expect_step(4'b0001);
    tick(1);
    expect_step(4'b1000);
    tick(4);
    mode = 2'b10; expect_step(4'b0100); tick(4);  // dir becomes 1
    mode = 2'b00; expect_step(4'b0010); tick(4);
    mode = 2'b10; expect_step(4'b0001); tick(4);  // dir 1 kept: shift right

    // Hold: step keeps pulsing, pattern stays.
    mode = 2'b11;
    expect_step(4'b0001); expect_step(4'b0001);
    tick(8);

    // Drop en at cnt=2 for 10 cycles.
    mode = 2'b00;
    tick(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("frozen_step", {31'd0, step}, 32'd0);
    end
    check("frozen_led", {28'd0, led}, 32'h1);
    en = 1'b1;
    expect_step(4'b1000);
    tick(1);
    check("resume_step_early", {31'd0, step}, 32'd0);
    tick(1);
    check("resume_step", {31'd0, step}, 32'd1);

    // en falls exactly at terminal count: the step waits for the next enabled edge.
    tick(3);
    en = 1'b0;
    tick(5);
    check("park_step", {31'd0, step}, 32'd0);
    en = 1'b1;
    expect_step(4'b0100);
    tick(1);
    check("park_fire", {31'd0, step}, 32'd1);

    // Asynchronous reset between edges while pat = 0100.
    tick(1);
    #6;
    check("pre_reset_led", {28'd0, led}, 32'h4);
    reset = 1'b1;
    #1;
    check("async_led", {28'd0, led}, 32'h0);
    check("async_step", {31'd0, step}, 32'd0);
    check("async_led_al", {28'd0, led_al}, 32'hF);
    en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(9);
    check("post_reset_pat", {28'd0, led}, 32'h1);
    en = 1'b1;
    expect_step(4'b1000);
    tick(3);
    check("post_reset_no_step", {31'd0, step}, 32'd0);
    tick(1);
    check("post_reset_step", {31'd0, step}, 32'd1);
    tick(1);
    en = 1'b0;
    tick(2);

    // Brightness with the pattern frozen at 1000.
    duty = 3'd3; tick(9); measure("duty3", 3);
    duty = 3'd0; tick(9); measure("duty0", 0);
    duty = 3'd7; tick(9); measure("duty7", 8);

    // Duty change mid-period: the old duty holds until pwm_cnt wraps.
    for (int k = 0; k < 8 && pwm_m != 3'd2; k++) tick(1);
    duty = 3'd0;
    hi_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (led == 4'b1000) hi_cnt++;
    end
    check("mid_old_duty", hi_cnt, 6);
    tick(1);
    check("mid_new_duty", {28'd0, led}, 32'h0);

    tick(2);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
